serial_tx: RTL and testbench
============================

# serial_tx

Byte-wide asynchronous serial (UART-style) transmitter producing 8N1 frames on a single line. A host presents a byte and pulses a load strobe. The block shifts out a start bit, eight data bits LSB first, and a stop bit, each held for a parameterised number of clocks. It sits between the CPU's serial-port register logic and the TX pin and reports idle status through `ready`.

## Interface
Parameters:
- `counterBits`, default 10: width of the internal bit-period counter.
- `delay`, default 868: clocks per bit (baud divisor). Legal range 1 ≤ delay ≤ 2^counterBits.

Ports:
- `clk`, input, 1: single clock; all state changes on rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `data`, input, 8: byte to transmit; sampled only on the accepting edge.
- `dataLoad`, input, 1: load request; rising-edge sensitive (0→1 transition between consecutive clock samples).
- `serialOut`, output, 1: serial line; idle high.
- `ready`, output, 1: high when idle and able to accept a load.

## Operation
- Registers:
  - state: IDLE or SEND.
  - 8-bit shift register.
  - 4-bit bit index (0 = start, 1–8 = data bits, 9 = stop).
  - `counterBits`-wide period counter.
  - `loadPrev`, the previous sample of `dataLoad`.
- Reset (async) values:
  - state = IDLE, `ready` = 1, `serialOut` = 1.
  - counter = 0, bit index = 0, shift register = 0, `loadPrev` = 0.
- `loadPrev` samples `dataLoad` every clock, regardless of state.
- Load accept condition: `dataLoad` = 1 and `loadPrev` = 0 and state = IDLE, all at the same rising edge.
- A constantly high `dataLoad` never triggers a second frame. The host must drop it for at least one clock before the next load.
- On accept:
  - capture `data` into the shift register.
  - enter SEND, drive `serialOut` = 0 (start bit), `ready` = 0.
  - counter = 0, bit index = 0.
- In SEND, each clock:
  - If counter < delay−1, increment the counter.
  - Otherwise reset the counter to 0 and advance the bit index.
  - Bits 1–8 output the shift register LSB, shifting right per bit (LSB first). Bit 9 outputs 1.
  - After bit 9 completes, go to IDLE with `ready` = 1 and `serialOut` = 1.
- Rising edges of `dataLoad` while in SEND are ignored and not queued. This includes an edge sampled on the same clock that ends the stop bit.
- Changes to `data` during SEND have no effect on the frame in flight.
- Reset asserted mid-frame aborts immediately: line goes high, `ready` goes high, the partial frame is discarded.
- `serialOut` and `ready` are registered outputs, with no combinational path from inputs.

## Timing
- Accepting edge E0 (the edge where the 0→1 of `dataLoad` is sampled):
  - From E0, `ready` = 0 and `serialOut` = start bit.
- Each of the 10 frame bits is held for exactly `delay` clocks.
- Bit k (0 = start … 9 = stop) is driven from E0 + k·delay to E0 + (k+1)·delay.
- `ready` returns to 1 at E0 + 10·delay; the line is already high from the stop bit.
- Busy duration is exactly 10·delay clocks.
- Earliest next accept: the edge after `ready` rises at which a fresh 0→1 of `dataLoad` is sampled. Back-to-back frames have no forced idle gap beyond that.

## Test plan
- **Idle after reset:** `ready` = 1 and `serialOut` = 1 with `dataLoad` low.
- **Basic frame:** delay = 3, counterBits = 2, load 0x65.
  - `ready` = 0 for 30 clocks.
  - Line reads 0, 1,0,1,0,0,1,1,0, 1, each bit for 3 clocks.
  - `ready` = 1 after the stop bit.
- **Level-held load:** keep `dataLoad` high after the frame ends and change `data` to 0xA0.
  - `ready` stays 1 and no new frame starts.
  - Drop `dataLoad` for 1 clock, then raise it: frame 0,0,0,0,0,0,1,0,1,1 (3 clocks each), then `ready` = 1.
- **Load during SEND:** toggle `dataLoad` and change `data` mid-frame.
  - The frame in flight is unchanged and no second frame follows.
- **Reset mid-frame:** assert `reset` during data bit 4.
  - `serialOut` = 1 and `ready` = 1 asynchronously; the next load sends a clean full frame.
- **Minimum divisor:** delay = 1, load 0xFF.
  - Line is 0 for 1 clock, then high for 9 clocks.
  - `ready` is low for exactly 10 clocks.

Source files
------------

// File: rtl/serial_tx_if.sv
// Host-side bundle for the 8N1 serial transmitter:
// byte, load strobe, serial line and idle status.
interface serial_tx_if;
   logic [7:0] data;
   logic       dataLoad;
   logic       serialOut;
   logic       ready;

   modport master (
      output data,
      output dataLoad,
      input  serialOut,
      input  ready
   );

   modport slave (
      input  data,
      input  dataLoad,
      output serialOut,
      output ready
   );
endinterface

// File: rtl/serial_tx.sv
// 8N1 serial transmitter: start bit, 8 data bits LSB first, stop bit,
// each held for delay clocks; load on a rising edge of dataLoad.
module serial_tx #(
   parameter int counterBits = 10,
   parameter int delay       = 868
) (
   input logic         clk,
   input logic         reset,
   serial_tx_if.slave  bus
);

   typedef enum logic {IDLE, SEND} state_t;

   localparam logic [counterBits-1:0] LAST = counterBits'(delay - 1);

   state_t                 r_state, w_state;
   logic [7:0]             r_shift, w_shift;
   logic [3:0]             r_idx, w_idx;
   logic [counterBits-1:0] r_cnt, w_cnt;
   logic                   r_out, w_out;
   logic                   r_ready, w_ready;
   logic                   r_loadPrev;
   logic                   w_accept;

   assign w_accept = bus.dataLoad & ~r_loadPrev;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= IDLE;
         r_shift    <= '0;
         r_idx      <= '0;
         r_cnt      <= '0;
         r_out      <= 1'b1;
         r_ready    <= 1'b1;
         r_loadPrev <= 1'b0;
      end else begin
         r_state    <= w_state;
         r_shift    <= w_shift;
         r_idx      <= w_idx;
         r_cnt      <= w_cnt;
         r_out      <= w_out;
         r_ready    <= w_ready;
         r_loadPrev <= bus.dataLoad;
      end
   end

   always_comb begin
      w_state = r_state;
      w_shift = r_shift;
      w_idx   = r_idx;
      w_cnt   = r_cnt;
      w_out   = r_out;
      w_ready = r_ready;
      unique case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_state = SEND;
               w_shift = bus.data;
               w_idx   = '0;
               w_cnt   = '0;
               w_out   = 1'b0;
               w_ready = 1'b0;
            end
         end
         SEND: begin
            if (r_cnt < LAST) begin
               w_cnt = r_cnt + 1'b1;
            end else begin
               w_cnt = '0;
               // Load edges arriving here are dropped, not queued.
               if (r_idx == 4'd9) begin
                  w_state = IDLE;
                  w_idx   = '0;
                  w_out   = 1'b1;
                  w_ready = 1'b1;
               end else begin
                  w_idx = r_idx + 4'd1;
                  if (r_idx == 4'd8) begin
                     w_out = 1'b1;
                  end else begin
                     w_out   = r_shift[0];
                     w_shift = {1'b0, r_shift[7:1]};
                  end
               end
            end
         end
         default: begin
            w_state = IDLE;
         end
      endcase
   end

   assign bus.serialOut = r_out;
   assign bus.ready     = r_ready;

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: delay=3 and delay=1 instances checked cycle by
// cycle against a queue of expected {serialOut, ready} samples.
module tb_serial_tx;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   serial_tx_if ifa ();
   serial_tx_if ifb ();

   serial_tx #(.counterBits(2), .delay(3)) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (ifa.slave)
   );

   serial_tx #(.counterBits(1), .delay(1)) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (ifb.slave)
   );

   typedef struct {
      int         w;
      logic [7:0] d;
      logic [9:0] f;
      int         mode;
      int         idle;
   } vec_t;

   vec_t       vt[7];
   logic [1:0] q[$];
   int         n_vec = 0;
   int         n_bad = 0;

   task automatic chk(input string nm, input logic [1:0] act,
                      input logic [1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: out/rdy=%b, expected %b", nm, act, exp);
      end
   endtask

   function automatic logic [1:0] sample(input int w);
      if (w == 0) return {ifa.serialOut, ifa.ready};
      return {ifb.serialOut, ifb.ready};
   endfunction

   task automatic drive(input int w, input logic ld, input logic [7:0] d);
      if (w == 0) begin
         ifa.dataLoad = ld;
         ifa.data     = d;
      end else begin
         ifb.dataLoad = ld;
         ifb.data     = d;
      end
   endtask

   // mode 0: drop load after accept; 1: hold it high;
   // 2: toggle load and scramble data during the frame.
   task automatic run(input vec_t v, input int id);
      int         dly;
      int         n;
      logic [1:0] e;
      logic [7:0] d;
      dly = (v.w == 0) ? 3 : 1;
      @(negedge clk);
      drive(v.w, 1'b0, v.d);
      @(negedge clk);
      drive(v.w, 1'b1, v.d);
      for (int k = 0; k < 10; k++)
         for (int j = 0; j < dly; j++)
            q.push_back({v.f[k], 1'b0});
      for (int k = 0; k <= v.idle; k++)
         q.push_back(2'b11);
      n = 0;
      while (q.size() > 0) begin
         @(posedge clk);
         #1;
         e = q.pop_front();
         chk($sformatf("v%0d cyc%0d", id, n), sample(v.w), e);
         if (v.mode == 0 && n == 0) begin
            drive(v.w, 1'b0, v.d);
         end else if (v.mode == 2 && n < 10 * dly) begin
            d = 8'($urandom);
            drive(v.w, (n % 2) == 1, d);
         end
         n++;
      end
   endtask

   initial begin
      vt[0] = '{0, 8'h65, 10'b1011001010, 1, 4};
      vt[1] = '{0, 8'hA0, 10'b1101000000, 0, 1};
      vt[2] = '{0, 8'hC3, 10'b1110000110, 2, 3};
      vt[3] = '{0, 8'h00, 10'b1000000000, 0, 0};
      vt[4] = '{0, 8'h5A, 10'b1010110100, 0, 1};
      vt[5] = '{1, 8'hFF, 10'b1111111110, 0, 2};
      vt[6] = '{1, 8'h5A, 10'b1010110100, 0, 1};

      reset = 1'b1;
      drive(0, 1'b0, 8'h00);
      drive(1, 1'b0, 8'h00);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("idle a", sample(0), 2'b11);
      chk("idle b", sample(1), 2'b11);

      for (int i = 0; i < 4; i++)
         run(vt[i], i);

      // abort during data bit 4 (clocks 12..14 after accept)
      @(negedge clk);
      drive(0, 1'b1, 8'h00);
      @(posedge clk);
      #1;
      drive(0, 1'b0, 8'h00);
      repeat (13) @(posedge clk);
      #1;
      chk("pre-reset bit4", sample(0), 2'b00);
      reset = 1'b1;
      #1;
      chk("async reset", sample(0), 2'b11);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("after reset", sample(0), 2'b11);

      for (int i = 4; i < 7; i++)
         run(vt[i], i);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
